// File: rtl/poly_pointwise_engine_if.sv
// Bus bundle for poly_pointwise_engine: control handshake, operand write port,
// result read port.
//   master: drives start/op/q, wr_en/wr_addr/wr_A/wr_B, rd_en/rd_addr
//   slave : drives busy, done, wr_err, rd_data
interface poly_pointwise_engine_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG_N  = 8
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] q;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [LOG_N-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_A;
  logic [DATA_W-1:0] wr_B;
  logic              wr_err;
  logic              rd_en;
  logic [LOG_N-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output start, op, q, wr_en, wr_addr, wr_A, wr_B, rd_en, rd_addr,
    input  busy, done, wr_err, rd_data
  );

  modport slave (
    input  start, op, q, wr_en, wr_addr, wr_A, wr_B, rd_en, rd_addr,
    output busy, done, wr_err, rd_data
  );
endinterface

// File: rtl/poly_pointwise_engine.sv
// Pointwise engine for NTT-domain polynomials: C[i] = op(A[i], B[i]) mod q,
// LANES coefficients per cycle through a 4-stage pipeline
// (read -> arithmetic -> reduce -> C write).
// Ports: clk, reset (async, active-high), bus (poly_pointwise_engine_if.slave).
// op: 0=MUL 1=ADD 2=SUB 3=COPY; with PWM_MAC_EN defined op 3 is
// MAC, C[i] = (C[i] + A[i]*B[i]) mod q. q==0 disables reduction.
module poly_pointwise_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG_N  = 8,
  parameter int unsigned LANES  = 1
) (
  input logic                   clk,
  input logic                   reset,
  poly_pointwise_engine_if.slave bus
);
  localparam int unsigned N  = 1 << LOG_N;
  localparam int unsigned PW = 2 * DATA_W;
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - LANES);
  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [LOG_N-1:0]  idx_q, idx_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [1:0]        drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;
  logic              issue_c;
  logic [DATA_W-1:0] rd_q;

  logic [DATA_W-1:0] mem_a [N];
  logic [DATA_W-1:0] mem_b [N];
  logic [DATA_W-1:0] mem_c [N];

  logic              s1_v, s2_v, s3_v;
  logic [LOG_N-1:0]  s1_idx, s2_idx, s3_idx;
  logic [DATA_W-1:0] s1_a [LANES];
  logic [DATA_W-1:0] s1_b [LANES];
`ifdef PWM_MAC_EN
  logic [DATA_W-1:0] s1_c [LANES];
`endif
  logic [PW-1:0]     s2_raw_c [LANES];
  logic [PW-1:0]     s2_raw [LANES];
  logic [DATA_W-1:0] s3_r [LANES];

  // Next-state, issue and registered-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    q_d      = q_q;
    drain_d  = drain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    issue_c  = 1'b0;
    wr_err_d = bus.wr_en && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          op_d    = bus.op;
          q_d     = bus.q;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        issue_c = 1'b1;
        idx_d   = idx_q + LOG_N'(LANES);
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        // Last group is written to C on the 3rd edge; done follows one edge later
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, pipeline valids and read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      op_q     <= OP_MUL;
      q_q      <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      rd_q     <= '0;
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s3_v     <= 1'b0;
      s1_idx   <= '0;
      s2_idx   <= '0;
      s3_idx   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      q_q      <= q_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      if (bus.rd_en) rd_q <= mem_c[bus.rd_addr];
      s1_v     <= issue_c;
      s2_v     <= s1_v;
      s3_v     <= s2_v;
      s1_idx   <= idx_q;
      s2_idx   <= s1_idx;
      s3_idx   <= s2_idx;
    end
  end

  // Stage 2 arithmetic; SUB pre-adds q so stage 3's single mod yields [0, q-1]
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      s2_raw_c[l] = '0;
      case (op_q)
        OP_MUL: s2_raw_c[l] = PW'(s1_a[l]) * PW'(s1_b[l]);
        OP_ADD: s2_raw_c[l] = PW'(s1_a[l]) + PW'(s1_b[l]);
        OP_SUB: s2_raw_c[l] = (q_q != '0)
                  ? PW'(s1_a[l]) + PW'(q_q) - PW'(s1_b[l] % q_q)
                  : PW'(DATA_W'(s1_a[l] - s1_b[l]));
`ifdef PWM_MAC_EN
        default: s2_raw_c[l] = PW'(s1_c[l]) + PW'(s1_a[l]) * PW'(s1_b[l]);
`else
        default: s2_raw_c[l] = PW'(s1_a[l]);
`endif
      endcase
    end
  end

  // Memories and pipeline data (not reset)
  always_ff @(posedge clk) begin
    if (bus.wr_en && (state_q == S_IDLE)) begin
      mem_a[bus.wr_addr] <= bus.wr_A;
      mem_b[bus.wr_addr] <= bus.wr_B;
    end
    for (int l = 0; l < int'(LANES); l++) begin
      s1_a[l] <= mem_a[idx_q + LOG_N'(l)];
      s1_b[l] <= mem_b[idx_q + LOG_N'(l)];
`ifdef PWM_MAC_EN
      s1_c[l] <= mem_c[idx_q + LOG_N'(l)];
`endif
      s2_raw[l] <= s2_raw_c[l];
      s3_r[l]   <= (q_q != '0) ? DATA_W'(s2_raw[l] % PW'(q_q)) : DATA_W'(s2_raw[l]);
      if (s3_v) mem_c[s3_idx + LOG_N'(l)] <= s3_r[l];
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_err  = wr_err_q;
  assign bus.rd_data = rd_q;
endmodule
